// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus between the datapath and pipe_ctrl.
// Carries the hazard inputs (source/destination registers, opcodes,
// mispredict, memory busy) and returns stall/bubble controls, the sticky
// memory timeout flag and the stall/flush performance counters.
// master: pipeline datapath side; slave: the controller.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       d_srcA;
  logic [4:0]       d_srcB;
  logic [5:0]       E_op;
  logic [4:0]       E_dstM;
  logic             e_mispredict;
  logic [5:0]       M_op;
  logic             m_busy;
  logic             F_stall;
  logic             D_stall;
  logic             E_stall;
  logic             M_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             W_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output d_srcA, d_srcB, E_op, E_dstM, e_mispredict, M_op, m_busy,
    input  F_stall, D_stall, E_stall, M_stall, D_bubble, E_bubble, W_bubble,
    input  mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  d_srcA, d_srcB, E_op, E_dstM, e_mispredict, M_op, m_busy,
    output F_stall, D_stall, E_stall, M_stall, D_bubble, E_bubble, W_bubble,
    output mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller.
// Decodes memory-hold, mispredict and load-use hazards into zero-latency
// stall/bubble controls, tracks long memory waits with a RUN/MEM_WAIT/ERR
// FSM, and keeps saturating stall and flush counters.
// Ports: clk, reset (synchronous, active-high), bus (pipe_ctrl_if.slave).
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16,
  parameter logic [5:0]  ILW     = 6'h23,
  parameter logic [5:0]  ISW     = 6'h2b
) (
  input  logic         clk,
  input  logic         reset,
  pipe_ctrl_if.slave   bus
);

  localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t            state;
  state_t            nextState;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] nextWaitCnt;
  logic              setTimeout;
  logic              memHold;
  logic              loadUse;
  logic              flushCase;

  // Hazard decode
  always_comb begin
    memHold = ((bus.M_op == ILW) || (bus.M_op == ISW)) && bus.m_busy;
    loadUse = (bus.E_op == ILW) && (bus.E_dstM != 5'd0) &&
              ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
    end
  end

  // Next-state logic; MEM_WAIT exits on m_busy alone, not on the opcode
  always_comb begin
    nextState   = state;
    nextWaitCnt = waitCnt;
    setTimeout  = 1'b0;
    case (state)
      RUN: begin
        if (memHold) begin
          nextState   = MEM_WAIT;
          nextWaitCnt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!bus.m_busy) begin
          nextState   = RUN;
          nextWaitCnt = '0;
        end else if (waitCnt == WAIT_W'(TIMEOUT)) begin
          nextState  = ERR;
          setTimeout = 1'b1;
        end else begin
          nextWaitCnt = waitCnt + WAIT_W'(1);
        end
      end
      ERR:     nextState = ERR;
      default: nextState = RUN;
    endcase
  end

  // Control outputs, combinational for zero-cycle pipeline response
  always_comb begin
    bus.F_stall  = 1'b0;
    bus.D_stall  = 1'b0;
    bus.E_stall  = 1'b0;
    bus.M_stall  = 1'b0;
    bus.D_bubble = 1'b0;
    bus.E_bubble = 1'b0;
    bus.W_bubble = 1'b0;
    flushCase    = 1'b0;
    if (reset) begin
      // fill the pipeline with nops while reset is held
      bus.D_bubble = 1'b1;
      bus.E_bubble = 1'b1;
      bus.W_bubble = 1'b1;
    end else if (state == ERR || memHold) begin
      bus.F_stall  = 1'b1;
      bus.D_stall  = 1'b1;
      bus.E_stall  = 1'b1;
      bus.M_stall  = 1'b1;
      bus.W_bubble = 1'b1;
    end else if (bus.e_mispredict) begin
      bus.D_bubble = 1'b1;
      bus.E_bubble = 1'b1;
      flushCase    = 1'b1;
    end else if (loadUse) begin
      bus.F_stall  = 1'b1;
      bus.D_stall  = 1'b1;
      bus.E_bubble = 1'b1;
    end
  end

  // Sticky timeout flag and saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_timeout <= 1'b0;
      bus.stall_cnt   <= '0;
      bus.flush_cnt   <= '0;
    end else begin
      if (setTimeout) begin
        bus.mem_timeout <= 1'b1;
      end
      if (bus.F_stall && (bus.stall_cnt != '1)) begin
        bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
      end
      if (flushCase && (bus.flush_cnt != '1)) begin
        bus.flush_cnt <= bus.flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard testbench for pipe_ctrl (TIMEOUT=4, CNT_W=4).
// The stimulus process drives one directed vector per cycle and queues the
// hand-computed response; the monitor checks it on the falling edge.
module tb_pipe_ctrl;

  localparam logic [5:0] LW = 6'h23;
  localparam logic [5:0] SW = 6'h2b;
  localparam logic [5:0] ADD = 6'h01;

  // {F_stall, D_stall, E_stall, M_stall, D_bubble, E_bubble, W_bubble}
  localparam logic [6:0] C_NONE = 7'b0000_000;
  localparam logic [6:0] C_RST  = 7'b0000_111;
  localparam logic [6:0] C_LU   = 7'b1100_010;
  localparam logic [6:0] C_MP   = 7'b0000_110;
  localparam logic [6:0] C_MEM  = 7'b1111_001;

  typedef struct packed {
    logic [15:0] id;
    logic [6:0]  ctl;
    logic        chk;
    logic [3:0]  sc;
    logic [3:0]  fc;
    logic        to;
  } exp_t;

  logic clk;
  logic reset;
  exp_t expQ[$];
  int   total;
  int   bad;
  int   stepNo;

  pipe_ctrl_if #(.CNT_W(4)) bus ();

  pipe_ctrl #(.TIMEOUT(4), .CNT_W(4), .ILW(LW), .ISW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic [4:0] srcA,
                      input logic [4:0] srcB, input logic [5:0] eOp,
                      input logic [4:0] eDst, input logic mp,
                      input logic [5:0] mOp, input logic busy,
                      input logic [6:0] ctl, input logic chk,
                      input int sc, input int fc, input logic to);
    exp_t e;
    @(posedge clk);
    #1;
    reset            = rst;
    bus.d_srcA       = srcA;
    bus.d_srcB       = srcB;
    bus.E_op         = eOp;
    bus.E_dstM       = eDst;
    bus.e_mispredict = mp;
    bus.M_op         = mOp;
    bus.m_busy       = busy;
    e.id  = 16'(stepNo);
    e.ctl = ctl;
    e.chk = chk;
    e.sc  = 4'(sc);
    e.fc  = 4'(fc);
    e.to  = to;
    expQ.push_back(e);
    stepNo++;
  endtask

  // Monitor: compare whatever the DUT presents against the queued response
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] got;
    if (expQ.size() > 0) begin
      e   = expQ.pop_front();
      got = {bus.F_stall, bus.D_stall, bus.E_stall, bus.M_stall,
             bus.D_bubble, bus.E_bubble, bus.W_bubble};
      total++;
      if (got !== e.ctl) begin
        bad++;
        $display("FAIL ctl step=%0d got=%b want=%b", e.id, got, e.ctl);
      end
      if (e.chk) begin
        total++;
        if (bus.stall_cnt !== e.sc) begin
          bad++;
          $display("FAIL stall_cnt step=%0d got=%0d want=%0d", e.id, bus.stall_cnt, e.sc);
        end
        total++;
        if (bus.flush_cnt !== e.fc) begin
          bad++;
          $display("FAIL flush_cnt step=%0d got=%0d want=%0d", e.id, bus.flush_cnt, e.fc);
        end
        total++;
        if (bus.mem_timeout !== e.to) begin
          bad++;
          $display("FAIL mem_timeout step=%0d got=%b want=%b", e.id, bus.mem_timeout, e.to);
        end
      end
    end
  end

  initial begin
    total  = 0;
    bad    = 0;
    stepNo = 0;
    reset  = 1'b1;
    bus.d_srcA = '0; bus.d_srcB = '0; bus.E_op = '0; bus.E_dstM = '0;
    bus.e_mispredict = 1'b0; bus.M_op = '0; bus.m_busy = 1'b0;

    //   rst srcA srcB eOp  eDst mp mOp busy ctl   chk sc fc to
    // reset and idle
    step(1, 0, 0, 0,   0, 0, 0,   0, C_RST,  0, 0, 0, 0);
    step(1, 0, 0, 0,   0, 0, 0,   0, C_RST,  1, 0, 0, 0);
    step(0, 0, 0, 0,   0, 0, 0,   0, C_NONE, 1, 0, 0, 0);
    // load-use, zero destination, non-load op
    step(0, 0, 5, LW,  5, 0, 0,   0, C_LU,   1, 0, 0, 0);
    step(0, 0, 0, 0,   0, 0, 0,   0, C_NONE, 1, 1, 0, 0);
    step(0, 0, 0, LW,  0, 0, 0,   0, C_NONE, 1, 1, 0, 0);
    step(0, 7, 3, LW,  7, 0, 0,   0, C_LU,   1, 1, 0, 0);
    step(0, 0, 5, LW,  5, 1, 0,   0, C_MP,   1, 2, 0, 0);
    step(0, 0, 0, 0,   0, 0, 0,   0, C_NONE, 1, 2, 1, 0);
    step(0, 5, 0, ADD, 5, 0, 0,   0, C_NONE, 1, 2, 1, 0);
    // store waits three cycles, mispredict ignored while held
    step(0, 0, 0, 0,   0, 0, SW,  1, C_MEM,  1, 2, 1, 0);
    step(0, 0, 5, LW,  5, 1, SW,  1, C_MEM,  1, 3, 1, 0);
    step(0, 0, 0, 0,   0, 0, SW,  1, C_MEM,  1, 4, 1, 0);
    step(0, 0, 0, 0,   0, 1, SW,  0, C_MP,   1, 5, 1, 0);
    step(0, 0, 0, 0,   0, 0, 0,   0, C_NONE, 1, 5, 2, 0);
    step(0, 0, 0, 0,   0, 0, ADD, 1, C_NONE, 1, 5, 2, 0);
    // reset in the second wait cycle
    step(0, 0, 0, 0,   0, 0, LW,  1, C_MEM,  1, 5, 2, 0);
    step(1, 0, 0, 0,   0, 0, LW,  1, C_RST,  1, 6, 2, 0);
    step(0, 0, 0, 0,   0, 0, LW,  0, C_NONE, 1, 0, 0, 0);
    // timeout into ERR, frozen until reset
    step(0, 0, 0, 0,   0, 0, LW,  1, C_MEM,  1, 0, 0, 0);
    step(0, 0, 0, 0,   0, 0, LW,  1, C_MEM,  1, 1, 0, 0);
    step(0, 0, 0, 0,   0, 0, LW,  1, C_MEM,  1, 2, 0, 0);
    step(0, 0, 0, 0,   0, 0, LW,  1, C_MEM,  1, 3, 0, 0);
    step(0, 0, 0, 0,   0, 0, LW,  1, C_MEM,  1, 4, 0, 0);
    step(0, 0, 0, 0,   0, 0, LW,  1, C_MEM,  1, 5, 0, 1);
    step(0, 0, 5, LW,  5, 1, 0,   0, C_MEM,  1, 6, 0, 1);
    step(0, 0, 0, 0,   0, 0, 0,   0, C_MEM,  1, 7, 0, 1);
    step(1, 0, 0, 0,   0, 0, 0,   0, C_RST,  1, 8, 0, 1);
    step(0, 0, 0, 0,   0, 0, 0,   0, C_NONE, 1, 0, 0, 0);
    // counter saturation at 15
    for (int i = 0; i < 20; i++)
      step(0, 0, 5, LW, 5, 0, 0, 0, C_LU, 1, (i > 15) ? 15 : i, 0, 0);
    step(0, 0, 0, 0,   0, 0, 0,   0, C_NONE, 1, 15, 0, 0);
    for (int i = 0; i < 17; i++)
      step(0, 0, 0, 0, 0, 1, 0, 0, C_MP, 1, 15, (i > 15) ? 15 : i, 0);
    step(0, 0, 0, 0,   0, 0, 0,   0, C_NONE, 1, 15, 15, 0);

    for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (expQ.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain pending=%0d want=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
